// File: rtl/lc3_mem_pkg.sv
// Shared states, requester ids and address-space bounds for the LC-3 memory controller.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } mem_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LD  = 1'b1;

  localparam logic [15:0] USER_SPACE_LO = 16'h3000;
  localparam logic [15:0] IO_SPACE_LO   = 16'hFE00;

endpackage

// File: rtl/lc3_rr_arb2.sv
// Two-way round-robin arbiter (CPU vs loader); last-grant pointer moves only on a grant.
module lc3_rr_arb2
  import lc3_mem_pkg::*;
(
  input  logic       i_CLK,
  input  logic       i_Reset_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic       o_valid,
  output logic       o_id
);

  logic last_q;

  always_comb begin
    o_valid = i_en & (|i_req);
    o_id    = REQ_CPU;
    if (i_req[REQ_CPU] && i_req[REQ_LD]) begin
      o_id = (last_q == REQ_LD) ? REQ_CPU : REQ_LD;
    end else if (i_req[REQ_LD]) begin
      o_id = REQ_LD;
    end
  end

  // Reset value makes the CPU win the first contested grant.
  always_ff @(posedge i_CLK) begin
    if (!i_Reset_n) begin
      last_q <= REQ_LD;
    end else if (o_valid) begin
      last_q <= o_id;
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// LC-3 memory-access controller: CPU/loader round-robin, wait states, R-bit generation.
// Optional user-mode access control violation check: define LC3_MEM_ACV_EN.
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              i_CLK,
  input  logic              i_Reset_n,
  input  logic              i_MIO_EN,
  input  logic              i_R_W,
  input  logic [ADDR_W-1:0] i_MAR,
  input  logic [DATA_W-1:0] i_MDR,
  input  logic              i_PSR_15,
  output logic [DATA_W-1:0] o_MEM_data,
  output logic              o_R_Bit,
  output logic              o_ACV,
  input  logic              i_ld_req,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_wdata,
  output logic              o_ld_gnt,
  output logic              o_ld_done,
  output logic [DATA_W-1:0] o_ld_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  mem_state_e        state_q, state_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              arb_en, gnt_valid, gnt_id, violation;
  logic [1:0]        req;
  logic              mem_en_d, mem_we_d, r_bit_d, acv_d, ld_gnt_d, ld_done_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, mem_data_d, ld_rdata_d;

  assign req    = {i_ld_req, i_MIO_EN};
  assign arb_en = (state_q == IDLE);

  lc3_rr_arb2 u_arb (
    .i_CLK     (i_CLK),
    .i_Reset_n (i_Reset_n),
    .i_en      (arb_en),
    .i_req     (req),
    .o_valid   (gnt_valid),
    .o_id      (gnt_id)
  );

`ifdef LC3_MEM_ACV_EN
  assign violation = (gnt_id == REQ_CPU) && i_PSR_15 &&
                     ((i_MAR < ADDR_W'(USER_SPACE_LO)) || (i_MAR >= ADDR_W'(IO_SPACE_LO)));
`else
  logic unused_psr;
  assign unused_psr = i_PSR_15;
  assign violation  = 1'b0;
`endif

  // Every output has a *_d twin so all outputs leave the flop bank directly.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = o_mem_addr;
    mem_wdata_d = o_mem_wdata;
    mem_data_d  = o_MEM_data;
    ld_rdata_d  = o_ld_rdata;
    r_bit_d     = 1'b0;
    acv_d       = 1'b0;
    ld_done_d   = 1'b0;
    ld_gnt_d    = o_ld_gnt;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          id_d = gnt_id;
          if (gnt_id == REQ_CPU) begin
            we_d        = i_R_W;
            mem_addr_d  = i_MAR;
            mem_wdata_d = i_MDR;
          end else begin
            we_d        = i_ld_we;
            mem_addr_d  = i_ld_addr;
            mem_wdata_d = i_ld_wdata;
          end
          if (violation) begin
            state_d = DONE;
            r_bit_d = 1'b1;
            acv_d   = 1'b1;
          end else begin
            state_d  = ISSUE;
            mem_en_d = 1'b1;
            mem_we_d = we_d;
            ld_gnt_d = (gnt_id == REQ_LD);
          end
        end
      end
      ISSUE: begin
        cnt_d   = WS_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        // Counter still at its load value marks the first WAIT cycle, when read data is valid.
        if ((cnt_q == WS_INIT) && !we_q) begin
          if (id_q == REQ_CPU) mem_data_d = i_mem_rdata;
          else                 ld_rdata_d = i_mem_rdata;
        end
        if (cnt_q == '0) begin
          state_d = DONE;
          if (id_q == REQ_CPU) r_bit_d   = 1'b1;
          else                 ld_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        ld_gnt_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_Reset_n) begin
      state_q     <= IDLE;
      id_q        <= REQ_CPU;
      we_q        <= '0;
      cnt_q       <= '0;
      o_mem_en    <= '0;
      o_mem_we    <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_MEM_data  <= '0;
      o_ld_rdata  <= '0;
      o_R_Bit     <= '0;
      o_ACV       <= '0;
      o_ld_done   <= '0;
      o_ld_gnt    <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      o_mem_en    <= mem_en_d;
      o_mem_we    <= mem_we_d;
      o_mem_addr  <= mem_addr_d;
      o_mem_wdata <= mem_wdata_d;
      o_MEM_data  <= mem_data_d;
      o_ld_rdata  <= ld_rdata_d;
      o_R_Bit     <= r_bit_d;
      o_ACV       <= acv_d;
      o_ld_done   <= ld_done_d;
      o_ld_gnt    <= ld_gnt_d;
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: three instances (2, 0, 15 wait states) share one stimulus stream.
`timescale 1ns/1ps
module tb_lc3_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        mio_en, r_w, psr, ld_req, ld_we;
  logic [15:0] mar, mdr, ld_addr, ld_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int inst, input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %0h expected %0h at %0t", inst, name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_i
    localparam int WS   = (gi == 0) ? 2 : ((gi == 1) ? 0 : 15);
    localparam int LAST = 3 + WS;

    logic        en, we, r_bit, acv, ld_gnt, ld_done;
    logic [15:0] addr, wdata, mem_data, ld_rdata, rdata;

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(WS)) u_dut (
      .i_CLK(clk), .i_Reset_n(rst_n), .i_MIO_EN(mio_en), .i_R_W(r_w), .i_MAR(mar),
      .i_MDR(mdr), .i_PSR_15(psr), .o_MEM_data(mem_data), .o_R_Bit(r_bit), .o_ACV(acv),
      .i_ld_req(ld_req), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
      .o_ld_gnt(ld_gnt), .o_ld_done(ld_done), .o_ld_rdata(ld_rdata),
      .o_mem_en(en), .o_mem_we(we), .o_mem_addr(addr), .o_mem_wdata(wdata),
      .i_mem_rdata(rdata));

    // Single-port synchronous memory attached to this instance.
    bit [15:0] mem [65536];
    bit        mem_init = 1'b0;
    always @(posedge clk) begin
      if (!mem_init) begin
        mem[16'h3000] = 16'h1234;
        mem_init      = 1'b1;
      end
      if (en === 1'b1) begin
        if (we === 1'b1) mem[addr] = wdata;
        else             rdata <= mem[addr];
      end
    end

    // Transaction-level model: t counts cycles since the grant edge (0 = no transaction).
    bit [15:0] shadow [65536];
    bit        sh_init = 1'b0;
    bit        live = 1'b0, last_ld = 1'b1;
    int        t = 0;
    bit        x_ld, x_we, x_acv;
    bit [15:0] x_addr, x_wdata, x_rd, e_mem_data, e_ld_rdata;

    always @(posedge clk) begin
      if (!sh_init) begin
        shadow[16'h3000] = 16'h1234;
        sh_init          = 1'b1;
      end
      if (rst_n == 1'b0) begin
        t = 0; live = 1'b1; last_ld = 1'b1;
        x_ld = 1'b0; x_we = 1'b0; x_acv = 1'b0;
        e_mem_data = '0; e_ld_rdata = '0;
      end else if (live) begin
        if (t == 0) begin
          if (mio_en || ld_req) begin
            x_ld    = ld_req && (!mio_en || !last_ld);
            last_ld = x_ld;
            x_we    = x_ld ? ld_we : r_w;
            x_addr  = x_ld ? ld_addr : mar;
            x_wdata = x_ld ? ld_wdata : mdr;
            x_acv   = 1'b0;
`ifdef LC3_MEM_ACV_EN
            x_acv   = !x_ld && psr && ((mar < 16'h3000) || (mar >= 16'hFE00));
`endif
            if (x_we && !x_acv) shadow[x_addr] = x_wdata;
            x_rd = shadow[x_addr];
            t    = 1;
          end
        end else if (t == (x_acv ? 1 : LAST)) begin
          t = 0;
        end else begin
          t++;
          if (t == 3 && !x_we) begin
            if (x_ld) e_ld_rdata = x_rd;
            else      e_mem_data = x_rd;
          end
        end
      end
    end

    always @(negedge clk) begin
      if (live) begin
        chk(gi, "mem_en",   en,      int'(t == 1 && !x_acv));
        chk(gi, "mem_we",   we,      int'(t == 1 && !x_acv && x_we));
        chk(gi, "r_bit",    r_bit,   int'(t != 0 && !x_ld && t == (x_acv ? 1 : LAST)));
        chk(gi, "acv",      acv,     int'(t == 1 && x_acv));
        chk(gi, "ld_done",  ld_done, int'(t != 0 && x_ld && t == LAST));
        chk(gi, "ld_gnt",   ld_gnt,  int'(t != 0 && x_ld));
        chk(gi, "mem_data", mem_data, e_mem_data);
        chk(gi, "ld_rdata", ld_rdata, e_ld_rdata);
        if (t == 1 && !x_acv) begin
          chk(gi, "mem_addr", addr, x_addr);
          if (x_we) chk(gi, "mem_wdata", wdata, x_wdata);
        end
      end
    end
  end

  int lat, en_cyc, we_cnt, acv_cnt, gnt_cnt;
  int seq[$];
  int lat_i[3];
  int r_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    mio_en = 1'b0; ld_req = 1'b0; psr = 1'b0;
    repeat (n) tick();
  endtask

  // Drives one access from idle and holds it until instance 0 reports completion.
  task automatic run_txn(input bit ld, input bit wr, input logic [15:0] a,
                         input logic [15:0] d, input bit user);
    lat = -1; en_cyc = -1; we_cnt = 0; acv_cnt = 0; gnt_cnt = 0;
    if (ld) begin
      ld_req = 1'b1; ld_we = wr; ld_addr = a; ld_wdata = d;
    end else begin
      mio_en = 1'b1; r_w = wr; mar = a; mdr = d; psr = user;
    end
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      tick();
      if (g_i[0].en && en_cyc < 0) en_cyc = c;
      if (g_i[0].we)     we_cnt++;
      if (g_i[0].acv)    acv_cnt++;
      if (g_i[0].ld_gnt) gnt_cnt++;
      if (ld ? g_i[0].ld_done : g_i[0].r_bit) lat = c;
    end
    mio_en = 1'b0; ld_req = 1'b0; psr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; mio_en = 1'b0; r_w = 1'b0; psr = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
    mar = '0; mdr = '0; ld_addr = '0; ld_wdata = '0;
    tick(); tick();
    chk(0, "reset_r_bit",    g_i[0].r_bit,    0);
    chk(0, "reset_mem_en",   g_i[0].en,       0);
    chk(0, "reset_mem_data", g_i[0].mem_data, 0);
    chk(0, "reset_ld_gnt",   g_i[0].ld_gnt,   0);
    rst_n = 1'b1;
    idle(3);

    // CPU read of preloaded word
    run_txn(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b0);
    chk(0, "rd_en_cycle",  en_cyc, 1);
    chk(0, "rd_latency",   lat,    5);
    chk(0, "rd_data",      g_i[0].mem_data, 16'h1234);

    // CPU write then read-back
    idle(25);
    run_txn(1'b0, 1'b1, 16'h4001, 16'hBEEF, 1'b0);
    chk(0, "wr_latency",   lat,    5);
    chk(0, "wr_we_cycles", we_cnt, 1);
    chk(0, "wr_data_hold", g_i[0].mem_data, 16'h1234);
    idle(25);
    run_txn(1'b0, 1'b0, 16'h4001, 16'h0000, 1'b0);
    chk(0, "rb_data",      g_i[0].mem_data, 16'hBEEF);

    // Loader write then read
    idle(25);
    run_txn(1'b1, 1'b1, 16'h0010, 16'h5555, 1'b0);
    chk(0, "ldw_latency",  lat,     5);
    chk(0, "ldw_gnt_cyc",  gnt_cnt, 5);
    idle(25);
    run_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    chk(0, "ldr_data",     g_i[0].ld_rdata, 16'h5555);
    chk(0, "ldr_cpu_hold", g_i[0].mem_data, 16'hBEEF);

    // Both requesting: last grant was the loader, so the CPU goes first
    idle(25);
    mio_en = 1'b1; r_w = 1'b0; mar = 16'h3000;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0010;
    seq.delete();
    for (int c = 1; c <= 47; c++) begin
      tick();
      if (g_i[0].r_bit)   seq.push_back(0);
      if (g_i[0].ld_done) seq.push_back(1);
    end
    idle(1);
    chk(0, "rr_pulses", seq.size(), 8);
    for (int k = 0; k < seq.size() && k < 8; k++) chk(0, "rr_order", seq[k], k % 2);
    chk(0, "rr_cpu_data", g_i[0].mem_data, 16'h1234);
    chk(0, "rr_ld_data",  g_i[0].ld_rdata, 16'h5555);

    // One-cycle request: latency per wait-state setting, completion despite the drop
    idle(25);
    mio_en = 1'b1; r_w = 1'b0; mar = 16'h4001;
    for (int i = 0; i < 3; i++) lat_i[i] = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 1) mio_en = 1'b0;
      if (g_i[0].r_bit && lat_i[0] < 0) lat_i[0] = c;
      if (g_i[1].r_bit && lat_i[1] < 0) lat_i[1] = c;
      if (g_i[2].r_bit && lat_i[2] < 0) lat_i[2] = c;
    end
    chk(0, "lat_ws2",  lat_i[0], 5);
    chk(1, "lat_ws0",  lat_i[1], 3);
    chk(2, "lat_ws15", lat_i[2], 18);
    chk(1, "ws0_data",  g_i[1].mem_data, 16'hBEEF);
    chk(2, "ws15_data", g_i[2].mem_data, 16'hBEEF);

    // Reset while instance 0 is in WAIT
    idle(25);
    mio_en = 1'b1; r_w = 1'b0; mar = 16'h3000;
    tick(); tick(); tick();
    rst_n = 1'b0; mio_en = 1'b0;
    tick();
    chk(0, "rst_wait_en",       g_i[0].en,       0);
    chk(0, "rst_wait_r_bit",    g_i[0].r_bit,    0);
    chk(0, "rst_wait_addr",     g_i[0].addr,     0);
    chk(0, "rst_wait_mem_data", g_i[0].mem_data, 0);
    chk(0, "rst_wait_ld_rdata", g_i[0].ld_rdata, 0);
    rst_n = 1'b1;
    r_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (g_i[0].r_bit) r_cnt++;
    end
    chk(0, "rst_no_r_bit", r_cnt, 0);
    run_txn(1'b0, 1'b0, 16'h4001, 16'h0000, 1'b0);
    chk(0, "post_rst_latency", lat, 5);
    chk(0, "post_rst_data",    g_i[0].mem_data, 16'hBEEF);

    // User-mode access below user space, then at its lower bound
    idle(25);
    run_txn(1'b0, 1'b0, 16'h0200, 16'h0000, 1'b1);
`ifdef LC3_MEM_ACV_EN
    chk(0, "acv_latency", lat,     1);
    chk(0, "acv_en",      en_cyc,  -1);
    chk(0, "acv_pulses",  acv_cnt, 1);
`else
    chk(0, "noacv_latency", lat,     5);
    chk(0, "noacv_en",      en_cyc,  1);
    chk(0, "noacv_pulses",  acv_cnt, 0);
`endif
    idle(25);
    run_txn(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b1);
    chk(0, "user_ok_latency", lat,     5);
    chk(0, "user_ok_acv",     acv_cnt, 0);
    chk(0, "user_ok_data",    g_i[0].mem_data, 16'h1234);

    idle(25);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Memory-access controller between the LC-3 datapath (MAR/MDR, MIO.EN, R.W from control store) and a single-port synchronous memory.
- Shares the memory with a second requester, the program loader/debug port, using 2-way round-robin arbitration.
- Inserts a configurable number of wait states and generates the R bit the microsequencer polls in its memory states.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- WAIT_STATES, 2, extra wait cycles per access (0..15).

Ports:
- i_CLK  input  1  clock.
- i_Reset_n  input  1  synchronous active-low reset.
- i_MIO_EN  input  1  CPU memory request, held by microcode until R seen.
- i_R_W  input  1  CPU direction: 1 = write, 0 = read.
- i_MAR  input  ADDR_W  CPU address.
- i_MDR  input  DATA_W  CPU write data.
- i_PSR_15  input  1  CPU privilege: 1 = user. Used only with the optional feature.
- o_MEM_data  output  DATA_W  last CPU read data.
- o_R_Bit  output  1  CPU access complete; one-cycle pulse.
- o_ACV  output  1  access control violation; one-cycle pulse.
- i_ld_req  input  1  loader request.
- i_ld_we  input  1  loader write.
- i_ld_addr  input  ADDR_W  loader address.
- i_ld_wdata  input  DATA_W  loader write data.
- o_ld_gnt  output  1  loader transaction in progress.
- o_ld_done  output  1  loader complete; one-cycle pulse.
- o_ld_rdata  output  DATA_W  last loader read data.
- o_mem_en  output  1  memory enable.
- o_mem_we  output  1  memory write enable.
- o_mem_addr  output  ADDR_W  memory address.
- o_mem_wdata  output  DATA_W  memory write data.
- i_mem_rdata  input  DATA_W  read data, valid the cycle after o_mem_en with o_mem_we = 0.

Behaviour:
- Reset (i_Reset_n low at a rising edge):
  - State goes to IDLE; all outputs become 0, including data registers.
  - Round-robin pointer favours the CPU.
  - An in-flight access is abandoned; no R or done pulse is produced.
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - CPU request only: grant CPU. Loader request only: grant loader.
  - Both requesting: grant the requester not granted last.
  - On grant, latch requester id, we, addr and wdata, then go to ISSUE.
- ISSUE (1 cycle):
  - o_mem_en = 1; o_mem_we, o_mem_addr and o_mem_wdata come from the latched values.
  - Load wait counter with WAIT_STATES; go to WAIT.
- WAIT (1 + WAIT_STATES cycles):
  - First cycle: for a read, capture i_mem_rdata into o_MEM_data (CPU) or o_ld_rdata (loader).
  - Counter decrements each cycle; when it reaches 0, go to DONE.
- DONE (1 cycle):
  - o_R_Bit = 1 (CPU) or o_ld_done = 1 (loader).
  - Always return to IDLE; a new request can be accepted the next cycle.
- Latency: request seen in IDLE at cycle 0 gives the completion pulse at cycle 3 + WAIT_STATES (5 at default).
- o_ld_gnt is 1 from ISSUE through DONE of a loader transaction.
- A write never modifies o_MEM_data or o_ld_rdata. Read data registers hold until the next read by the same requester.
- Request dropped mid-transaction: the access still completes and the pulse is still issued.
- Memory idle: o_mem_en and o_mem_we are 0 in every state except ISSUE.

Optional Feature:
- Macro: LC3_MEM_ACV_EN.
- Enabled:
  - In IDLE, a granted CPU access with i_PSR_15 = 1 and i_MAR < 16'h3000 or i_MAR >= 16'hFE00 is a violation.
  - A violation skips ISSUE and WAIT and goes straight to DONE: o_R_Bit = 1 and o_ACV = 1 at cycle 1, no o_mem_en.
  - Loader accesses are never checked.
- Disabled: o_ACV is tied to 0 and i_PSR_15 is ignored.

Decomposition:
- Package lc3_mem_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/DONE);
  - the requester id constants (REQ_CPU = 0, REQ_LD = 1);
  - the bounds USER_SPACE_LO = 16'h3000 and IO_SPACE_LO = 16'hFE00.
- Sub-module lc3_rr_arb2: 2-input round-robin arbiter with a last-grant pointer, updated only on grant.

Test Plan:
- CPU read: memory[0x3000] = 0x1234, i_MIO_EN = 1, i_R_W = 0, i_MAR = 0x3000 → o_mem_en at cycle 1, o_R_Bit pulse at cycle 5, o_MEM_data = 0x1234.
- CPU write 0xBEEF to 0x4001, then read 0x4001 → o_mem_we = 1 only in ISSUE; read returns 0xBEEF; o_MEM_data unchanged by the write.
- CPU and loader both requesting continuously → grants alternate CPU, LD, CPU, LD…; each completion pulses once and nothing is starved.
- Run with WAIT_STATES = 0 → pulse at cycle 3. Run with WAIT_STATES = 15 → pulse at cycle 18.
- Reset asserted in WAIT → next cycle all outputs are 0 and state is IDLE; no o_R_Bit; a fresh request completes normally.
- With LC3_MEM_ACV_EN, i_PSR_15 = 1, i_MAR = 0x0200 → o_R_Bit and o_ACV at cycle 1, o_mem_en never asserted. Without the macro → normal access and o_ACV = 0.
